// File: rtl/umai_chn_striper_if.sv
// Stream bundle between the UMAI protocol engine, the AIB channel bank and
// the channel striper.
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. Valid is never derived from ready on the same interface. A
// producer holds valid and data stable until the transfer completes.
//
// Modport "slave" is the striper itself. Modport "master" is its
// environment: the upstream producer, the channel bank and the downstream
// consumer.
interface umai_chn_striper_if #(
    parameter int NumChannels = 6,
    parameter int DataWidth   = 72
);
    // Upstream transmit flit stream
    logic                   i_valid;
    logic                   o_ready;
    logic [DataWidth-1:0]   i_data;
    // Per-channel transmit
    logic [NumChannels-1:0] o_tx_valid;
    logic [NumChannels-1:0] i_tx_ready;
    logic [DataWidth-1:0]   o_tx_data [NumChannels];
    // Per-channel receive
    logic [NumChannels-1:0] i_rx_valid;
    logic [NumChannels-1:0] o_rx_ready;
    logic [DataWidth-1:0]   i_rx_data [NumChannels];
    // Downstream receive flit stream
    logic                   o_valid;
    logic                   i_ready;
    logic [DataWidth-1:0]   o_data;

    modport slave (
        input  i_valid, i_data, i_tx_ready, i_rx_valid, i_rx_data, i_ready,
        output o_ready, o_tx_valid, o_tx_data, o_rx_ready, o_valid, o_data
    );

    modport master (
        output i_valid, i_data, i_tx_ready, i_rx_valid, i_rx_data, i_ready,
        input  o_ready, o_tx_valid, o_tx_data, o_rx_ready, o_valid, o_data
    );
endinterface

// File: rtl/umai_chn_striper.sv
// Round-robin flit striper between the UMAI engine and the AIB channel bank.
// Transmit spreads one flit stream over channels first..last in ascending
// order. Receive gathers the stream back from the same range in the same
// order. Stopping waits until both pointers return to the first channel, so
// both dies stay aligned on a stripe boundary.
module umai_chn_striper #(
    parameter int NumChannels = 6,
    parameter int DataWidth   = 72,
    parameter int IdW         = $clog2(NumChannels)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           c_enable,
    input  logic [IdW-1:0] c_first_chn_id,
    input  logic [IdW-1:0] c_last_chn_id,
    output logic           o_cfg_err,
    output logic           o_active,
    output logic [15:0]    o_tx_cnt,
    output logic [15:0]    o_rx_cnt,
    output logic [1:0]     o_dbg_state,   // 0 IDLE, 1 RUN, 2 STOP
    umai_chn_striper_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_e;

    localparam logic [IdW:0] ChnLimit = (IdW+1)'(NumChannels);

    state_e         state_q;
    logic           active_q;
    logic [IdW-1:0] tx_ptr_q, tx_ptr_d;
    logic [IdW-1:0] rx_ptr_q, rx_ptr_d;
    logic [15:0]    tx_cnt_q, rx_cnt_q;

    logic           cfg_err;
    logic           tx_at_first, rx_at_first;
    logic           tx_live, rx_live;
    logic           tx_sel_ready, rx_sel_valid;
    logic [DataWidth-1:0] rx_sel_data;
    logic           tx_hs, rx_hs;

    // Range must be ordered and lie inside the channel bank.
    assign cfg_err = (c_first_chn_id > c_last_chn_id) ||
                     ({1'b0, c_last_chn_id} >= ChnLimit);

    assign tx_at_first = (tx_ptr_q == c_first_chn_id);
    assign rx_at_first = (rx_ptr_q == c_first_chn_id);

    // A side moves flits in RUN, and in STOP only until it is back at the
    // first channel. A bad configuration silences both sides at once.
    assign tx_live = !cfg_err && ((state_q == ST_RUN) ||
                                  ((state_q == ST_STOP) && !tx_at_first));
    assign rx_live = !cfg_err && ((state_q == ST_RUN) ||
                                  ((state_q == ST_STOP) && !rx_at_first));

    // Next channel in the stripe, wrapping at the last channel.
    assign tx_ptr_d = (tx_ptr_q == c_last_chn_id) ? c_first_chn_id : tx_ptr_q + IdW'(1);
    assign rx_ptr_d = (rx_ptr_q == c_last_chn_id) ? c_first_chn_id : rx_ptr_q + IdW'(1);

    // Select the pointed-to channel's handshake inputs.
    always_comb begin
        tx_sel_ready = 1'b0;
        rx_sel_valid = 1'b0;
        rx_sel_data  = '0;
        for (int k = 0; k < NumChannels; k++) begin
            if (IdW'(k) == tx_ptr_q) begin
                tx_sel_ready = bus.i_tx_ready[k];
            end
            if (IdW'(k) == rx_ptr_q) begin
                rx_sel_valid = bus.i_rx_valid[k];
                rx_sel_data  = bus.i_rx_data[k];
            end
        end
    end

    // Steer the upstream flit and the downstream ready to one channel each.
    always_comb begin
        bus.o_tx_valid = '0;
        bus.o_rx_ready = '0;
        for (int k = 0; k < NumChannels; k++) begin
            bus.o_tx_data[k]  = bus.i_data;
            bus.o_tx_valid[k] = tx_live && (IdW'(k) == tx_ptr_q) && bus.i_valid;
            bus.o_rx_ready[k] = rx_live && (IdW'(k) == rx_ptr_q) && bus.i_ready;
        end
    end

    assign bus.o_ready = tx_live && tx_sel_ready;
    assign bus.o_valid = rx_live && rx_sel_valid;
    assign bus.o_data  = rx_sel_data;

    assign tx_hs = bus.i_valid && bus.o_ready;
    assign rx_hs = bus.o_valid && bus.i_ready;

    // Run/stop state machine with both stripe pointers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ST_IDLE;
            active_q <= 1'b0;
            tx_ptr_q <= '0;
            rx_ptr_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_ptr_q <= c_first_chn_id;
                    rx_ptr_q <= c_first_chn_id;
                    if (c_enable && !cfg_err) begin
                        state_q  <= ST_RUN;
                        active_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (cfg_err) begin
                        state_q  <= ST_IDLE;
                        active_q <= 1'b0;
                    end else begin
                        if (tx_hs) tx_ptr_q <= tx_ptr_d;
                        if (rx_hs) rx_ptr_q <= rx_ptr_d;
                        if (!c_enable) state_q <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (cfg_err) begin
                        state_q  <= ST_IDLE;
                        active_q <= 1'b0;
                    end else begin
                        if (tx_hs) tx_ptr_q <= tx_ptr_d;
                        if (rx_hs) rx_ptr_q <= rx_ptr_d;
                        if (c_enable) begin
                            state_q <= ST_RUN;
                        end else if (tx_at_first && rx_at_first) begin
                            state_q  <= ST_IDLE;
                            active_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    active_q <= 1'b0;
                end
            endcase
        end
    end

    // Completed-handshake counters; they survive IDLE and clear only on reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (tx_hs) tx_cnt_q <= tx_cnt_q + 16'd1;
            if (rx_hs) rx_cnt_q <= rx_cnt_q + 16'd1;
        end
    end

    assign o_cfg_err   = cfg_err;
    assign o_active    = active_q;
    assign o_tx_cnt    = tx_cnt_q;
    assign o_rx_cnt    = rx_cnt_q;
    assign o_dbg_state = state_q;

endmodule

// File: doc/umai_chn_striper.md
# umai_chn_striper

Round-robin flit scheduler between the UMAI protocol engine and the bank of AIB channels. On transmit it spreads a single 72-bit flit stream across a configurable contiguous range of channels, one flit per channel in ascending order. On receive it gathers flits from the same channel range in the same order and rebuilds the stream. Start and stop are stripe-aligned, so transmit and receive pointers on both dies always agree on which channel carries the next flit.

## Interface
Parameters:
- NumChannels, 6, number of AIB channels.
- DataWidth, 72, flit width in bits; matches the AIB channel data width.
- IdW, $clog2(NumChannels), channel-index width.

Ports:
- i_clk  in  1  block clock.
- i_rst_n  in  1  reset; asynchronous, active-low.
- c_enable  in  1  run request.
- c_first_chn_id  in  IdW  first channel of the stripe range.
- c_last_chn_id  in  IdW  last channel of the stripe range, inclusive.
- o_cfg_err  out  1  configuration out of range.
- o_active  out  1  state is RUN or STOP.
- i_valid / o_ready / i_data  in / out / DataWidth  upstream transmit flit stream.
- o_tx_valid[NumChannels] / i_tx_ready[NumChannels] / o_tx_data[NumChannels]  out / in / DataWidth each  per-channel transmit.
- i_rx_valid[NumChannels] / o_rx_ready[NumChannels] / i_rx_data[NumChannels]  in / out / DataWidth each  per-channel receive.
- o_valid / i_ready / o_data  out / in / DataWidth  downstream receive flit stream.
- o_tx_cnt, o_rx_cnt  out  16 each  count of completed flit handshakes.

## Operation
- **Configuration check.** o_cfg_err = (c_first_chn_id > c_last_chn_id) or (c_last_chn_id >= NumChannels). The check is combinational and applies in every state.
- **Pointers.** Two registers, tx_ptr and rx_ptr, each IdW bits.
  - A pointer advances only on a handshake on its own side.
  - It advances by one; when it equals c_last_chn_id it wraps to c_first_chn_id.
- **Transmit, RUN or STOP state.**
  - o_tx_valid[tx_ptr] = i_valid; every other o_tx_valid is 0.
  - o_tx_data[k] = i_data for all k.
  - o_ready = i_tx_ready[tx_ptr].
- **Receive, RUN or STOP state.**
  - o_valid = i_rx_valid[rx_ptr]; o_data = i_rx_data[rx_ptr].
  - o_rx_ready[rx_ptr] = i_ready; every other o_rx_ready is 0.
- **State machine (IDLE, RUN, STOP).**
  - IDLE: all valid and ready outputs are 0. Both pointers load c_first_chn_id every cycle.
  - IDLE -> RUN: when c_enable=1 and o_cfg_err=0.
  - RUN -> STOP: when c_enable=0.
  - RUN -> IDLE: when o_cfg_err=1, immediately. Any stripe in progress is abandoned.
  - STOP: each side keeps transferring until its pointer is back at c_first_chn_id.
    - A side whose pointer already equals c_first_chn_id is gated: o_ready=0 for transmit, o_valid=0 for receive. Its per-channel outputs are 0.
    - STOP -> IDLE: when both pointers equal c_first_chn_id.
    - STOP -> RUN: when c_enable returns to 1 before that. Pointers are kept.
- **Configuration changes.** c_first_chn_id and c_last_chn_id may change only in IDLE. Changes in other states are not supported, apart from the cfg_err abort.
- **Counters.** o_tx_cnt increments on each i_valid&o_ready. o_rx_cnt increments on each o_valid&i_ready. Both wrap from 0xFFFF to 0. Both clear on reset only; they are not cleared by IDLE.
- **Single-channel range** (first==last): the pointer stays constant and the stream passes straight through one channel.

## Timing
- Reset values: state=IDLE; tx_ptr=rx_ptr=0; counters=0. All o_tx_valid, o_rx_ready, o_ready and o_valid are 0. o_active=0.
- The data path is combinational: zero-cycle latency upstream to channel and channel to downstream. There is no buffering.
- Pointer, counter and state updates take effect on the i_clk edge of the handshake or transition. The next flit is steered to the new pointer in the following cycle.
- o_active is registered state decode: it rises one cycle after the enable edge is sampled.
- Handshake rules:
  - Valid must not depend on ready on the upstream side.
  - The block's valid outputs do not depend on its own ready inputs.
  - A held upstream flit stays on the same channel until it is accepted.
- Simultaneous transmit and receive handshakes in one cycle are independent. Both counters update.
- Asserting reset mid-stripe returns to IDLE at once. Partial stripes are lost; the software re-enables both dies.

## Test plan
- **Reset.** Assert i_rst_n=0 mid-traffic -> all valid/ready outputs 0, counters 0, o_active=0 in the same cycle.
- **Full-range transmit.** first=0, last=5, enable, push 14 flits (D0..D13) with all i_tx_ready=1 -> Dn appears on channel n mod 6. o_tx_cnt=14.
- **Partial-range receive.** first=2, last=4. Drive channels 2,3,4 with A,B,C and then D. Assert i_rx_valid[3] early, before channel 2 -> o_valid stays 0 until channel 2 is valid. Output order is A,B,C,D, and channel 3 is not acknowledged before A is taken.
- **Stripe-aligned stop.** Range 0..3, two flits sent, c_enable=0 -> exactly two more flits are accepted (channels 2,3). Then o_ready=0 and state is IDLE one cycle later.
- **Configuration error.** first=4, last=1, c_enable=1 -> o_cfg_err=1, state stays IDLE, no ready asserted. Also: last=6 while in RUN -> IDLE on the next edge.
- **Backpressure and wrap.** Hold i_tx_ready[1]=0 for 5 cycles with i_valid=1 -> o_tx_valid[1] stays high with stable data, tx_ptr is unchanged, no other channel is valid. Separately, preload 0xFFFF handshakes -> o_tx_cnt wraps to 0.
